// File: rtl/rr_mux_ctrl_if.sv
// Handshake and data bundle between the round-robin mux controller, its two
// request channels, the external 2:1 data mux and the downstream consumer.
interface rr_mux_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              req_0;
    logic              req_1;
    logic              ack_0;
    logic              ack_1;
    logic              sel;
    logic [DATA_W-1:0] mux_out;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              dout_src;

    // The controller sits on the slave side; the environment (requesters, mux,
    // consumer) drives the master side.
    modport slave (
        input  req_0, req_1, mux_out, dout_ready,
        output ack_0, ack_1, sel, dout, dout_valid, dout_src
    );

    modport master (
        output req_0, req_1, mux_out, dout_ready,
        input  ack_0, ack_1, sel, dout, dout_valid, dout_src
    );
endinterface

// File: rtl/rr_mux_ctrl.sv
// Round-robin arbiter driving a 2:1 mux select, plus a one-entry output register.
// Optional macro RR_BURST_EN lets a channel keep up to MAX_BURST consecutive grants.
module rr_mux_ctrl #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           reset,
    rr_mux_ctrl_if.slave   bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t            state;
    logic              last_grant;
    logic              winner;
    logic              load_ok;
    logic              ack_0;
    logic              ack_1;
    logic              xfer;
    logic [DATA_W-1:0] dout_q;
    logic              src_q;

    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
        $error("rr_mux_ctrl: MAX_BURST must be in 1..15");
    end

`ifdef RR_BURST_EN
    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);
    logic [3:0] burst_cnt;
    logic       stay;

    // A zero count means no burst is in progress yet, so contention alternates.
    assign stay = (burst_cnt != 4'd0) && (burst_cnt < BURST_LIMIT);
`endif

    // NOTE: the default assignment first keeps this combinational block latch-free.
    always_comb begin
        winner = 1'b0;
        if (bus.req_0 && bus.req_1) begin
`ifdef RR_BURST_EN
            winner = stay ? last_grant : ~last_grant;
`else
            winner = ~last_grant;
`endif
        end else if (bus.req_1) begin
            winner = 1'b1;
        end
    end

    // A slot opens when empty, or when the held beat drains this same cycle.
    assign load_ok = (state == EMPTY) || bus.dout_ready;
    assign ack_0   = load_ok & bus.req_0 & ~winner;
    assign ack_1   = load_ok & bus.req_1 &  winner;
    assign xfer    = ack_0 | ack_1;

    assign bus.ack_0      = ack_0;
    assign bus.ack_1      = ack_1;
    assign bus.sel        = winner;
    assign bus.dout       = dout_q;
    assign bus.dout_src   = src_q;
    assign bus.dout_valid = (state == FULL);

    // NOTE: state updates use non-blocking assignments so every register samples
    // the pre-edge values; the data register is reset too so dout reads 0 after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            dout_q     <= '0;
            src_q      <= 1'b0;
            last_grant <= 1'b1;
`ifdef RR_BURST_EN
            burst_cnt  <= 4'd0;
`endif
        end else begin
            if (xfer) begin
                state      <= FULL;
                dout_q     <= bus.mux_out;
                src_q      <= winner;
                last_grant <= winner;
            end else if (state == FULL && bus.dout_ready) begin
                state <= EMPTY;
            end
`ifdef RR_BURST_EN
            if (xfer) begin
                if (winner != last_grant || burst_cnt == 4'd0) begin
                    burst_cnt <= 4'd1;
                end else if (burst_cnt < BURST_LIMIT) begin
                    burst_cnt <= burst_cnt + 4'd1;
                end
            end
`endif
        end
    end
endmodule
